ram_loader_ctrl: RTL and testbench

- Main-memory stage that sits directly downstream of the 8-bit cpu and serves its RAM-in (c_ri) and RAM-out (c_ro) strobes at the address on addr_bus.
- Adds a power-on clear sequencer and a byte-stream program loader.
- Holds the cpu stalled through cpu_hold while memory is cleared or loaded, then returns to normal RAM service.

---
 rtl/ram_loader_ctrl.sv | 171 +++++++++++++++++
 tb/tb_ram_loader_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_loader_ctrl.sv
// Main-memory stage for the 8-bit cpu: power-on clear, byte-stream program loader, RAM service.
// Optional LOAD_CSUM_EN adds the load_sum checksum port.
module ram_loader_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr_bus,
  input  logic              c_ri,
  input  logic              c_ro,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  output logic              cpu_hold,
  input  logic              prog_start,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              prog_valid,
  input  logic              prog_last,
  output logic              prog_ready,
  output logic              load_ovf,
  output logic              rw_err
`ifdef LOAD_CSUM_EN
  ,
  output logic [DATA_W-1:0] load_sum
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_RUN,
    ST_LOAD
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              load_ovf_q, load_ovf_d;
  logic              rw_err_q, rw_err_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic ptr_at_end;
  logic load_xfer;

  assign ptr_at_end = (ptr_q == {ADDR_W{1'b1}});
  assign load_xfer  = (state_q == ST_LOAD) && prog_valid;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      ptr_q      <= '0;
      load_ovf_q <= 1'b0;
      rw_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      load_ovf_q <= load_ovf_d;
      rw_err_q   <= rw_err_d;
    end
  end

  // NOTE: the array has no reset; the CLEAR sequence zeroes it one word per cycle instead.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // NOTE: every comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    load_ovf_d = load_ovf_q;
    rw_err_d   = rw_err_q;
    mem_we     = 1'b0;
    mem_waddr  = ptr_q;
    mem_wdata  = '0;
    case (state_q)
      ST_CLEAR: begin
        mem_we = 1'b1;
        ptr_d  = ptr_q + ADDR_W'(1);
        if (ptr_at_end) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (c_ri && !c_ro) begin
          mem_we    = 1'b1;
          mem_waddr = addr_bus;
          mem_wdata = bus_in;
        end
        if (c_ri && c_ro) begin
          rw_err_d = 1'b1;
        end
        if (prog_start) begin
          state_d    = ST_LOAD;
          ptr_d      = '0;
          load_ovf_d = 1'b0;
        end
      end
      ST_LOAD: begin
        if (load_xfer) begin
          mem_we    = 1'b1;
          mem_wdata = prog_data;
          ptr_d     = ptr_q + ADDR_W'(1);
          if (prog_last) begin
            state_d = ST_RUN;
          end else if (ptr_at_end) begin
            state_d    = ST_RUN;
            load_ovf_d = 1'b1;
          end
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // Reset forces the stalled, bus-released outputs even before the state flop updates.
  always_comb begin
    cpu_hold   = 1'b1;
    prog_ready = 1'b0;
    bus_oe     = 1'b0;
    bus_out    = '0;
    if (!reset) begin
      case (state_q)
        ST_RUN: begin
          cpu_hold = 1'b0;
          bus_oe   = c_ro;
          if (c_ro) begin
            bus_out = mem[addr_bus];
          end
        end
        ST_LOAD:  prog_ready = 1'b1;
        default:  prog_ready = 1'b0;
      endcase
    end
  end

  assign load_ovf = load_ovf_q;
  assign rw_err   = rw_err_q;

`ifdef LOAD_CSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (state_q == ST_RUN && prog_start) begin
      sum_d = '0;
    end else if (load_xfer) begin
      sum_d = sum_q + prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign load_sum = sum_q;
`endif

endmodule

// File: tb/tb_ram_loader_ctrl.sv
// Scoreboard bench for ram_loader_ctrl: randomized RAM traffic and loads against an array model.
module tb_ram_loader_ctrl;

  localparam int DEPTH = 256;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] addr_bus = '0;
  logic       c_ri = 1'b0;
  logic       c_ro = 1'b0;
  logic [7:0] bus_in = '0;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic       cpu_hold;
  logic       prog_start = 1'b0;
  logic [7:0] prog_data = '0;
  logic       prog_valid = 1'b0;
  logic       prog_last = 1'b0;
  logic       prog_ready;
  logic       load_ovf;
  logic       rw_err;
`ifdef LOAD_CSUM_EN
  logic [7:0] load_sum;
`endif

  ram_loader_ctrl #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .addr_bus   (addr_bus),
    .c_ri       (c_ri),
    .c_ro       (c_ro),
    .bus_in     (bus_in),
    .bus_out    (bus_out),
    .bus_oe     (bus_oe),
    .cpu_hold   (cpu_hold),
    .prog_start (prog_start),
    .prog_data  (prog_data),
    .prog_valid (prog_valid),
    .prog_last  (prog_last),
    .prog_ready (prog_ready),
    .load_ovf   (load_ovf),
    .rw_err     (rw_err)
`ifdef LOAD_CSUM_EN
    ,
    .load_sum   (load_sum)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: memory contents and sticky flags as the cpu/loader would see them.
  logic [7:0] model_mem [DEPTH];
  bit         model_ovf;
  bit         model_rw;
  logic [7:0] model_sum;
  logic [7:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every cycle the bus is driven, the oldest expected read must match.
  always @(negedge clk) begin
    if (bus_oe === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read actual=%0h required=none", bus_out);
      end else begin
        check("bus_out", bus_out, exp_q.pop_front());
      end
    end else begin
      check("bus_out_idle", bus_out, 8'h00);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
    model_ovf = 1'b0;
    model_rw  = 1'b0;
    model_sum = 8'h00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("reset_hold", cpu_hold, 1'b1);
    check("reset_ready", prog_ready, 1'b0);
    tick();
    reset = 1'b0;
    model_reset();
    check("clear_hold", cpu_hold, 1'b1);
    check("clear_ready", prog_ready, 1'b0);
  endtask

  // Counts stalled cycles after reset; a stray prog_start during CLEAR must be ignored.
  task automatic wait_clear(output int n);
    n = 0;
    while (cpu_hold === 1'b1 && n < 1000) begin
      prog_start = (n == 10);
      tick();
      prog_start = 1'b0;
      n++;
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_load_ovf"}, load_ovf, model_ovf);
    check({tag, "_rw_err"}, rw_err, model_rw);
`ifdef LOAD_CSUM_EN
    check({tag, "_load_sum"}, load_sum, model_sum);
`endif
  endtask

  task automatic ram_write(input logic [7:0] a, input logic [7:0] d);
    addr_bus = a; bus_in = d; c_ri = 1'b1;
    tick();
    c_ri = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic ram_read(input logic [7:0] a);
    addr_bus = a; c_ro = 1'b1;
    exp_q.push_back(model_mem[a]);
    tick();
    c_ro = 1'b0;
  endtask

  task automatic ram_both(input logic [7:0] a, input logic [7:0] d);
    addr_bus = a; bus_in = d; c_ri = 1'b1; c_ro = 1'b1;
    exp_q.push_back(model_mem[a]);
    tick();
    c_ri = 1'b0; c_ro = 1'b0;
    model_rw = 1'b1;
  endtask

  task automatic start_load();
    prog_start = 1'b1;
    tick();
    prog_start = 1'b0;
    model_ovf = 1'b0;
    model_sum = 8'h00;
    check("load_hold", cpu_hold, 1'b1);
    check("load_ready", prog_ready, 1'b1);
    check("load_ovf_cleared", load_ovf, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] d, input bit last);
    repeat ($urandom_range(0, 2)) tick();
    prog_data = d; prog_valid = 1'b1; prog_last = last;
    tick();
    prog_valid = 1'b0; prog_last = 1'b0;
  endtask

  // fixed < 0 sends random bytes; with_last flags the final byte as prog_last.
  task automatic run_load(input int n, input bit with_last, input int fixed);
    logic [7:0] b;
    start_load();
    for (int i = 0; i < n; i++) begin
      b = (fixed < 0) ? 8'($urandom) : 8'(fixed);
      if (i > 0 && cpu_hold !== 1'b1) check("load_still_held", cpu_hold, 1'b1);
      send_byte(b, with_last && (i == n - 1));
      model_mem[i % DEPTH] = b;
      model_sum = model_sum + b;
    end
    if (!with_last && n == DEPTH) model_ovf = 1'b1;
    check("load_done_hold", cpu_hold, 1'b0);
    check("load_done_ready", prog_ready, 1'b0);
    check_flags("load_done");
  endtask

  initial begin
    int n;
    model_reset();

    // Power-on clear, then plant 0xAA at 0x42 and clear again.
    do_reset();
    wait_clear(n);
    check("clear_cycles_first", n, 256);
    ram_write(8'h42, 8'hAA);
    ram_read(8'h42);
    do_reset();
    wait_clear(n);
    check("clear_cycles", n, 256);
    ram_read(8'h42);
    check_flags("after_clear");

    // Directed read/write and simultaneous strobes.
    ram_write(8'h10, 8'h5C);
    ram_read(8'h10);
    ram_write(8'h20, 8'h11);
    check("rw_err_before", rw_err, 1'b0);
    ram_both(8'h20, 8'h99);
    check("rw_err_set", rw_err, 1'b1);
    ram_read(8'h20);
    check("rw_err_sticky", rw_err, 1'b1);

    // Random RAM traffic over a small window so addresses collide.
    for (int i = 0; i < 150; i++) begin
      logic [7:0] a;
      a = 8'($urandom_range(0, 15));
      case ($urandom_range(0, 9))
        0:       ram_both(a, 8'($urandom));
        1, 2, 3: ram_write(a, 8'($urandom));
        default: ram_read(a);
      endcase
    end
    check_flags("after_random_run");

    // Three-byte load with gaps; mem[3] must survive.
    ram_write(8'h03, 8'h77);
    start_load();
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    check("mid_load_hold", cpu_hold, 1'b1);
    send_byte(8'h03, 1'b1);
    model_mem[0] = 8'h01; model_mem[1] = 8'h02; model_mem[2] = 8'h03;
    model_sum = 8'h06;
    check("short_load_hold", cpu_hold, 1'b0);
    check_flags("short_load");
    for (int a = 0; a < 4; a++) ram_read(8'(a));

    // Random-length loads, then read back the affected region.
    for (int k = 0; k < 3; k++) begin
      run_load($urandom_range(1, 12), 1'b1, -1);
      for (int a = 0; a < 16; a++) ram_read(8'(a));
    end

    // Overflow: 256 bytes of 0xFF and no prog_last.
    run_load(DEPTH, 1'b0, 8'hFF);
    ram_read(8'h00);
    ram_read(8'hFF);
    ram_write(8'h30, 8'h3C);
    ram_read(8'h30);
    check_flags("after_ovf_run");

    // Reset mid-load after five bytes.
    start_load();
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b0);
    check("pre_reset_hold", cpu_hold, 1'b1);
    do_reset();
    wait_clear(n);
    check("clear_cycles_midload", n, 256);
    check_flags("after_midload_reset");
    for (int a = 0; a < DEPTH; a++) ram_read(8'(a));

    tick();
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
